// File: rtl/alu_frame_pkg.sv
// Shared definitions for the ALU command-frame sequencer.
package alu_frame_pkg;

    // Sequencer states: frame collection, ALU run/capture, two-byte transmit.
    typedef enum logic [3:0] {
        IDLE,
        GET_A,
        GET_B,
        GET_FUN,
        ALU_RUN,
        CAPTURE,
        SEND_LO,
        WAIT_LO,
        SEND_HI,
        WAIT_HI
    } state_t;

    localparam logic [7:0] CMD_ALU_DEF = 8'hCC;  // frame header byte
    localparam logic [3:0] FUN_MAX     = 4'hE;   // highest legal function code
    localparam int         FRAME_LEN   = 4;      // header, A, B, FUN

endpackage

// File: rtl/alu_frame_ctrl.sv
// Command-side ALU sequencer: collects CC/A/B/FUN frames from the byte
// receiver, pulses the ALU, captures its 16-bit result and ships it to the
// byte transmitter low byte first. Every output is a register.
module alu_frame_ctrl
    import alu_frame_pkg::*;
#(
    parameter int                    DATA_WIDTH    = 8,
    parameter int                    OUT_WIDTH     = 16,
    parameter int                    ALU_FUN_WIDTH = 4,
    parameter logic [DATA_WIDTH-1:0] CMD_ALU       = DATA_WIDTH'(CMD_ALU_DEF)
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [DATA_WIDTH-1:0]    RX_P_DATA,
    input  logic                     RX_D_VLD,
    input  logic [OUT_WIDTH-1:0]     ALU_OUT,
    input  logic                     OUT_Valid,
    input  logic                     TX_BUSY,
    output logic [DATA_WIDTH-1:0]    ALU_A,
    output logic [DATA_WIDTH-1:0]    ALU_B,
    output logic [ALU_FUN_WIDTH-1:0] ALU_FUN,
    output logic                     ALU_EN,
    output logic [DATA_WIDTH-1:0]    TX_P_DATA,
    output logic                     TX_D_VLD,
    output logic                     CMD_ERR
);

    state_t                   state, state_nxt;
    logic [OUT_WIDTH-1:0]     result, result_nxt;
    logic                     busy_seen, busy_seen_nxt;  // WAIT_*: transmitter has gone busy
    logic [DATA_WIDTH-1:0]    a_nxt, b_nxt, tx_data_nxt;
    logic [ALU_FUN_WIDTH-1:0] fun_nxt;
    logic                     en_nxt, tx_vld_nxt, err_nxt;
    logic                     fun_ok;

    // FUN byte is legal only with a zero upper field and code <= FUN_MAX.
    assign fun_ok = ((RX_P_DATA >> ALU_FUN_WIDTH) == '0) &&
                    (RX_P_DATA[ALU_FUN_WIDTH-1:0] <= ALU_FUN_WIDTH'(FUN_MAX));

    // Next-state and next-output decode; pulses default low, data holds.
    always_comb begin
        state_nxt     = state;
        result_nxt    = result;
        busy_seen_nxt = busy_seen;
        a_nxt         = ALU_A;
        b_nxt         = ALU_B;
        fun_nxt       = ALU_FUN;
        tx_data_nxt   = TX_P_DATA;
        en_nxt        = 1'b0;
        tx_vld_nxt    = 1'b0;
        err_nxt       = 1'b0;
        case (state)
            IDLE:    if (RX_D_VLD && RX_P_DATA == CMD_ALU) state_nxt = GET_A;
            GET_A:   if (RX_D_VLD) begin a_nxt = RX_P_DATA; state_nxt = GET_B; end
            GET_B:   if (RX_D_VLD) begin b_nxt = RX_P_DATA; state_nxt = GET_FUN; end
            GET_FUN: if (RX_D_VLD) begin
                if (fun_ok) begin
                    fun_nxt   = RX_P_DATA[ALU_FUN_WIDTH-1:0];
                    en_nxt    = 1'b1;
                    state_nxt = ALU_RUN;
                end else begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            ALU_RUN: state_nxt = CAPTURE;
            CAPTURE: begin
                if (OUT_Valid) begin
                    result_nxt = ALU_OUT;
                    state_nxt  = SEND_LO;
                end else begin
                    err_nxt    = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            SEND_LO: if (!TX_BUSY) begin
                tx_data_nxt = result[DATA_WIDTH-1:0];
                tx_vld_nxt  = 1'b1;
                state_nxt   = WAIT_LO;
            end
            SEND_HI: if (!TX_BUSY) begin
                tx_data_nxt = result[OUT_WIDTH-1:DATA_WIDTH];
                tx_vld_nxt  = 1'b1;
                state_nxt   = WAIT_HI;
            end
            WAIT_LO, WAIT_HI: begin
                if (!busy_seen) begin
                    if (TX_BUSY) busy_seen_nxt = 1'b1;
                end else if (!TX_BUSY) begin
                    busy_seen_nxt = 1'b0;
                    state_nxt     = (state == WAIT_LO) ? SEND_HI : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, result and registered outputs; reset abandons any frame in flight.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= IDLE;
            result    <= '0;
            busy_seen <= 1'b0;
            ALU_A     <= '0;
            ALU_B     <= '0;
            ALU_FUN   <= '0;
            ALU_EN    <= 1'b0;
            TX_P_DATA <= '0;
            TX_D_VLD  <= 1'b0;
            CMD_ERR   <= 1'b0;
        end else begin
            state     <= state_nxt;
            result    <= result_nxt;
            busy_seen <= busy_seen_nxt;
            ALU_A     <= a_nxt;
            ALU_B     <= b_nxt;
            ALU_FUN   <= fun_nxt;
            ALU_EN    <= en_nxt;
            TX_P_DATA <= tx_data_nxt;
            TX_D_VLD  <= tx_vld_nxt;
            CMD_ERR   <= err_nxt;
        end
    end

endmodule

// File: tb/tb_alu_frame_ctrl.sv
// Scoreboard bench for alu_frame_ctrl: stimulus pushes expected ALU
// launches, TX bytes and errors; a negedge monitor pops and compares.
module tb_alu_frame_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic [7:0]  RX_P_DATA;
    logic        RX_D_VLD;
    logic [15:0] ALU_OUT = '0;
    logic        OUT_Valid = 1'b0;
    logic        TX_BUSY;
    logic [7:0]  ALU_A, ALU_B, TX_P_DATA;
    logic [3:0]  ALU_FUN;
    logic        ALU_EN, TX_D_VLD, CMD_ERR;

    alu_frame_ctrl dut (
        .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .ALU_OUT(ALU_OUT), .OUT_Valid(OUT_Valid), .TX_BUSY(TX_BUSY),
        .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN),
        .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .CMD_ERR(CMD_ERR)
    );

    always #5 CLK = ~CLK;

    int tests = 0, fails = 0, cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference ALU behaviour used both by the ALU stand-in and the scoreboard.
    function automatic logic [15:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
        case (f)
            4'd0:    return 16'(a) + 16'(b);
            4'd1:    return 16'(a) - 16'(b);
            4'd2:    return 16'(a) * 16'(b);
            4'd3:    return (b == 0) ? 16'd0 : 16'(a / b);
            4'd4:    return {8'h00, a & b};
            4'd5:    return {8'h00, a | b};
            4'd6:    return {8'h00, a ^ b};
            default: return {a ^ b, f, ~f};
        endcase
    endfunction

    // ALU stand-in: registered result one cycle after ALU_EN; can withhold valid.
    bit drop_valid = 0;
    always @(posedge CLK) begin
        OUT_Valid <= ALU_EN && !drop_valid;
        if (ALU_EN) ALU_OUT <= alu_ref(ALU_A, ALU_B, ALU_FUN);
    end

    // Transmitter stand-in: busy for busy_len cycles after each strobe.
    int busy_cnt = 0, busy_len = 2;
    bit busy_force = 0;
    always @(posedge CLK) begin
        if (TX_D_VLD)          busy_cnt <= busy_len;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign TX_BUSY = (busy_cnt > 0) || busy_force;

    // Scoreboard queues.
    logic [7:0]  exp_tx[$];
    logic [19:0] exp_en[$];
    int          err_pending = 0;

    // Monitor: compare every DUT event against the scoreboard.
    bit prev_tx = 0, prev_en = 0, lat_pending = 0;
    int en_cyc = 0, tx_lat = -1;
    always @(negedge CLK) begin
        cyc++;
        if (RST) begin
            if (TX_D_VLD) begin
                if (exp_tx.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_tx: got byte 0x%0h, expected no strobe", TX_P_DATA);
                end else check("tx_byte", TX_P_DATA, exp_tx.pop_front());
                check("tx_vld_while_busy", TX_BUSY, 0);
                check("tx_vld_back_to_back", prev_tx, 0);
                if (lat_pending) begin tx_lat = cyc - en_cyc; lat_pending = 0; end
            end
            if (ALU_EN) begin
                if (exp_en.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_alu_en: got A=%0h B=%0h F=%0h, expected no launch", ALU_A, ALU_B, ALU_FUN);
                end else check("alu_operands", {ALU_A, ALU_B, ALU_FUN}, exp_en.pop_front());
                check("alu_en_width", prev_en, 0);
                en_cyc = cyc;
                lat_pending = 1;
            end
            if (CMD_ERR) begin
                tests++;
                if (err_pending > 0) err_pending--;
                else begin
                    fails++;
                    $display("FAIL unexpected_cmd_err: got 1, expected 0");
                end
            end
            prev_tx = TX_D_VLD;
            prev_en = ALU_EN;
        end else begin
            prev_tx = 0;
            prev_en = 0;
        end
    end

    task automatic tick();
        @(posedge CLK); #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input int gapmax);
        RX_P_DATA = d;
        RX_D_VLD  = 1'b1;
        tick();
        RX_D_VLD  = 1'b0;
        repeat ($urandom_range(0, gapmax)) tick();
    endtask

    // Issue one frame and record what the DUT must do with it.
    task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] f, input int gapmax);
        logic [15:0] r;
        if (f <= 8'h0E) begin
            exp_en.push_back({a, b, f[3:0]});
            if (drop_valid) err_pending++;
            else begin
                r = alu_ref(a, b, f[3:0]);
                exp_tx.push_back(r[7:0]);
                exp_tx.push_back(r[15:8]);
            end
        end else err_pending++;
        send_byte(8'hCC, gapmax);
        send_byte(a, gapmax);
        send_byte(b, gapmax);
        send_byte(f, gapmax);
    endtask

    // Wait for the scoreboard to drain and the transmitter to go quiet.
    task automatic wait_done(input string name);
        int n = 0;
        while ((exp_tx.size() != 0 || exp_en.size() != 0 || err_pending != 0) && n < 400) begin
            tick(); n++;
        end
        check({name, "_timeout"}, n < 400, 1);
        if (n >= 400) begin exp_tx.delete(); exp_en.delete(); err_pending = 0; end
        repeat (2) tick();
        n = 0;
        while (TX_BUSY && n < 100) begin tick(); n++; end
        repeat (2) tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] a, b, f, j;
        bit any_vld;
        int n;
        RST = 1'b0; RX_P_DATA = '0; RX_D_VLD = 1'b0;
        repeat (3) tick();
        check("rst_alu_a", ALU_A, 0);
        check("rst_alu_b", ALU_B, 0);
        check("rst_alu_fun", ALU_FUN, 0);
        check("rst_alu_en", ALU_EN, 0);
        check("rst_tx_data", TX_P_DATA, 0);
        check("rst_tx_vld", TX_D_VLD, 0);
        check("rst_cmd_err", CMD_ERR, 0);
        RST = 1'b1;
        repeat (2) tick();

        // Add: 0x12 + 0x34, also measures ALU_EN-to-first-strobe latency.
        busy_len = 2;
        send_frame(8'h12, 8'h34, 8'h00, 0);
        wait_done("add");
        check("first_tx_latency", tx_lat, 3);

        // Multiply: 0xFF * 0xFF = 0xFE01.
        send_frame(8'hFF, 8'hFF, 8'h02, 1);
        wait_done("mul");

        // Illegal FUN: one CMD_ERR, no launch, no transmit.
        send_frame(8'h05, 8'h03, 8'h1F, 0);
        wait_done("bad_fun");

        // Transmitter held busy: no strobe until it drops; stray bytes ignored.
        busy_force = 1;
        send_frame(8'h21, 8'h10, 8'h00, 0);
        any_vld = 0;
        for (int i = 0; i < 22; i++) begin
            if (i == 6)  RX_P_DATA = 8'h55;
            if (i == 9)  RX_P_DATA = 8'hCC;
            if (i == 12) RX_P_DATA = 8'hAA;
            RX_D_VLD = (i == 6 || i == 9 || i == 12);
            @(negedge CLK);
            any_vld |= TX_D_VLD;
            tick();
        end
        RX_D_VLD = 1'b0;
        check("held_busy_no_strobe", any_vld, 0);
        busy_force = 0;
        @(negedge CLK);
        check("strobe_not_before_release", TX_D_VLD, 0);
        @(negedge CLK);
        check("strobe_after_release", TX_D_VLD, 1);
        #1;
        wait_done("held_busy");

        // Reset in WAIT_LO: outputs clear at once, high byte never sent.
        busy_len = 6;
        send_frame(8'h3C, 8'h0F, 8'h05, 0);
        n = 0;
        while (exp_tx.size() > 1 && n < 100) begin tick(); n++; end
        check("reach_wait_lo", n < 100, 1);
        tick();
        RST = 1'b0;
        #1;
        check("arst_outputs", {ALU_A, ALU_B, ALU_FUN, ALU_EN, TX_P_DATA, TX_D_VLD, CMD_ERR}, 0);
        exp_tx.delete();
        repeat (2) tick();
        RST = 1'b1;
        wait_done("post_reset_quiet");
        busy_len = 2;
        send_frame(8'h08, 8'h02, 8'h03, 0);
        wait_done("div_after_reset");

        // Junk in IDLE, then a normal frame.
        send_byte(8'h55, 1);
        send_byte(8'hAA, 1);
        send_frame(8'h9A, 8'h5C, 8'h01, 1);
        wait_done("junk_idle");

        // Randomised frames: legal/illegal FUN, missing result, gaps, junk.
        for (int i = 0; i < 40; i++) begin
            busy_len   = $urandom_range(1, 4);
            drop_valid = ($urandom_range(0, 9) == 0);
            a = 8'($urandom);
            b = 8'($urandom);
            if ($urandom_range(0, 4) == 0)
                f = $urandom_range(0, 1) ? 8'h0F : {4'($urandom_range(1, 15)), 4'($urandom)};
            else
                f = 8'($urandom_range(0, 14));
            if ($urandom_range(0, 2) == 0) begin
                j = 8'($urandom);
                if (j == 8'hCC) j = 8'h55;
                send_byte(j, 1);
            end
            send_frame(a, b, f, 2);
            wait_done("random");
            drop_valid = 0;
        end

        check("exp_tx_left", exp_tx.size(), 0);
        check("exp_en_left", exp_en.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
